// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: frame length, counter width and counter end-mode encodings.
package ps2_pkg;

    // Bit slots in a PS/2 frame: start, 8 data, parity, stop.
    localparam int PS2_FRAME_BITS = 11;

    // Counter width that covers a full frame.
    localparam int PS2_CNT_W = 4;

    // End-of-range behaviour encodings for the SATURATE parameter.
    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

endpackage : ps2_pkg

// File: rtl/mod_counter.sv
// Parametrised synchronous modulo counter with enable, parallel load,
// up/down direction, wrap/saturate mode, terminal-count and wrap flags.
// q always stays inside 0..MODULUS-1.
module mod_counter
    import ps2_pkg::*;
#(
    parameter int WIDTH    = PS2_CNT_W,
    parameter int MODULUS  = PS2_FRAME_BITS,
    parameter int SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // Reject illegal parameter combinations at elaboration.
    if ((WIDTH < 2) || (WIDTH > 16)) begin : g_bad_width
        $error("mod_counter: WIDTH must be in 2..16");
    end
    if (MODULUS < 2) begin : g_bad_mod_low
        $error("mod_counter: MODULUS must be at least 2");
    end
    if (64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_mod_high
        $error("mod_counter: MODULUS must not exceed 2**WIDTH");
    end

    // Last legal count value and small constants, all WIDTH bits wide.
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               SAT_MODE = (SATURATE == CNT_SAT);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;

    // Next-state: load (clamped) beats count; counting compares before
    // stepping so q never passes through a value >= MODULUS.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (load) begin
            q_d    = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            wrap_d = 1'b0;
        end else if (en) begin
            if (up) begin
                if (q_q < MAX_VAL) begin
                    q_d    = q_q + ONE_VAL;
                    wrap_d = 1'b0;
                end else begin
                    q_d    = SAT_MODE ? q_q : ZERO_VAL;
                    wrap_d = 1'b1;
                end
            end else begin
                if (q_q > ZERO_VAL) begin
                    q_d    = q_q - ONE_VAL;
                    wrap_d = 1'b0;
                end else begin
                    q_d    = SAT_MODE ? q_q : MAX_VAL;
                    wrap_d = 1'b1;
                end
            end
        end else begin
            q_d    = q_q;
            wrap_d = 1'b0;
        end
    end

    // Count and wrap registers; clear wins over every other input.
    always_ff @(posedge clk) begin
        if (clear) begin
            q_q    <= ZERO_VAL;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign tc   = (up & (q_q == MAX_VAL)) | (~up & (q_q == ZERO_VAL));

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: a vector table for the wrap-mode 4-bit/11
// counter, plus hand sequences for saturate mode and a full-range 3-bit/8 counter.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic       up = 1'b1;
    logic [3:0] load_val = 4'd0;

    logic [3:0] q_w, q_s;
    logic       tc_w, tc_s, wrap_w, wrap_s;
    logic [2:0] q_f;
    logic       tc_f, wrap_f;
    logic [2:0] load_val_f;

    int checks = 0;
    int failures = 0;

    assign load_val_f = load_val[2:0];

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MODULUS(11), .SATURATE(0)) dut_w (
        .clk(clk), .clear(clear), .en(en), .load(load), .load_val(load_val),
        .up(up), .q(q_w), .tc(tc_w), .wrap(wrap_w));

    mod_counter #(.WIDTH(4), .MODULUS(11), .SATURATE(1)) dut_s (
        .clk(clk), .clear(clear), .en(en), .load(load), .load_val(load_val),
        .up(up), .q(q_s), .tc(tc_s), .wrap(wrap_s));

    mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) dut_f (
        .clk(clk), .clear(clear), .en(en), .load(load), .load_val(load_val_f),
        .up(up), .q(q_f), .tc(tc_f), .wrap(wrap_f));

    typedef struct {
        logic       clear;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] lv;
        logic [3:0] exp_q;
        logic       exp_wrap;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic c, input logic l, input logic e, input logic u,
                                input logic [3:0] lv, input logic [3:0] eq,
                                input logic ew, input logic et);
        vec_t v;
        v.clear = c; v.load = l; v.en = e; v.up = u; v.lv = lv;
        v.exp_q = eq; v.exp_wrap = ew; v.exp_tc = et;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0d required=%0d", nm, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, settle away from it.
    task automatic step(input logic c, input logic l, input logic e, input logic u, input logic [3:0] lv);
        clear = c; load = l; en = e; up = u; load_val = lv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held 2 cycles with en/load active; up=1 so tc=0.
        add(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0);
        // Reset value of tc with up=0 is 1.
        add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
        // Count up 0..10, then wrap to 0, then 1.
        for (int i = 1; i <= 10; i++)
            add(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'(i), 1'b0, (i == 10) ? 1'b1 : 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
        // Down wrap from 0 to 10, then hold drops wrap.
        add(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd10, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd10, 1'b0, 1'b0);
        // Load beats enable; clamp; clear beats load.
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 4'd10, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 4'd0, 1'b0, 1'b0);
        // Hold at 6 for 3 cycles, mid-count clear, resume.
        add(1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 4'd6, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            add(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd6, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
        // Direction change takes effect on the sampled edge.
        add(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0);

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].clear, vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].lv);
            chk("wrap_mode_q", i, 32'(q_w), 32'(vecs[i].exp_q));
            chk("wrap_mode_wrap", i, 32'(wrap_w), 32'(vecs[i].exp_wrap));
            chk("wrap_mode_tc", i, 32'(tc_w), 32'(vecs[i].exp_tc));
        end

        // Saturate mode, down at 0: q holds, wrap high each enabled cycle.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("sat_reset_q", 0, 32'(q_s), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
            chk("sat_down_q", i, 32'(q_s), 32'd0);
            chk("sat_down_wrap", i, 32'(wrap_s), 32'd1);
            chk("sat_down_tc", i, 32'(tc_s), 32'd1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("sat_idle_q", 0, 32'(q_s), 32'd0);
        chk("sat_idle_wrap", 0, 32'(wrap_s), 32'd0);
        // Saturate mode, up at top: hold at 10.
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
        chk("sat_load_q", 0, 32'(q_s), 32'd10);
        chk("sat_load_wrap", 0, 32'(wrap_s), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
            chk("sat_up_q", i, 32'(q_s), 32'd10);
            chk("sat_up_wrap", i, 32'(wrap_s), 32'd1);
            chk("sat_up_tc", i, 32'(tc_s), 32'd1);
        end

        // Full-range modulus: 3 bits, modulus 8, count 0..7 then 0.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        chk("full_reset_q", 0, 32'(q_f), 32'd0);
        begin
            int wraps;
            wraps = 0;
            for (int i = 0; i < 9; i++) begin
                step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
                chk("full_q", i, 32'(q_f), 32'((i + 1) % 8));
                chk("full_wrap", i, 32'(wrap_f), (i == 7) ? 32'd1 : 32'd0);
                chk("full_tc", i, 32'(tc_f), (i == 6) ? 32'd1 : 32'd0);
                if (wrap_f === 1'b1) wraps++;
            end
            chk("full_wrap_count", 0, 32'(wraps), 32'd1);
        end
        // Full-range down wrap from 0 to 7.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("full_down_q", 0, 32'(q_f), 32'd7);
        chk("full_down_wrap", 0, 32'(wrap_f), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mod_counter
